// File: rtl/uart_bus_host.sv
// uart_bus_host: turns local bus reads/writes into UART command bytes and parses the remote reply,
// while passing bit7=0 data-channel bytes through in both directions.
module uart_bus_host #(
  parameter int TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy,
  output logic [7:0]  o_tx_dat,
  output logic        o_tx_start,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_received_pulse,
  input  logic [7:0]  i_stream_dat,
  input  logic        i_stream_valid,
  output logic        o_stream_ready,
  output logic [7:0]  o_stream_dat,
  output logic        o_stream_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  state_t state, state_d;
  logic we, we_d, got_hi, got_hi_d, err_d, tx_start_d, stream_ready_d;
  logic [15:0] addr, addr_d;
  logic [7:0] wdat, wdat_d, dat_d, tx_dat_d;
  logic [2:0] idx, idx_d, tag;
  logic [3:0] nib, hi, hi_d;
  logic [CW-1:0] cnt, cnt_d;
  logic can_tx, rx_cmd, rx_data, rsp_ok;
  assign o_ack = state == DONE;
  assign o_busy = state != IDLE;
  // a start in the previous cycle blocks this one so uart_tx has time to drop ready
  assign can_tx = i_tx_ready && !o_tx_start;
  assign rx_cmd = i_rx_received_pulse && i_rx_dat[7];
  assign rx_data = i_rx_received_pulse && !i_rx_dat[7];
  assign rsp_ok = got_hi && i_rx_dat[6:4] == 3'd5;
  // byte idx walks addr nibbles, then data nibbles (write only), then the execute tag
  always_comb begin
    tag = !idx[2] ? idx : !we ? 3'd6 : (idx == 3'd6) ? 3'd7 : idx;
    nib = (we || !idx[2]) ? 4'(({addr, wdat, 8'h00} << {idx, 2'b00}) >> 28) : 4'h0;
  end
  always_comb begin
    state_d = state;
    we_d = we;
    addr_d = addr;
    wdat_d = wdat;
    idx_d = idx;
    cnt_d = cnt;
    hi_d = hi;
    got_hi_d = got_hi;
    dat_d = o_dat;
    err_d = o_err;
    tx_dat_d = o_tx_dat;
    tx_start_d = 1'b0;
    stream_ready_d = 1'b0;
    case (state)
      IDLE: if (i_cs) begin
        state_d = SEND;
        we_d = i_we;
        addr_d = i_addr;
        wdat_d = i_dat;
        idx_d = 3'd0;
      end
      SEND: if (can_tx) begin
        tx_start_d = 1'b1;
        tx_dat_d = {1'b1, tag, nib};
        idx_d = idx + 3'd1;
        if (idx == (we ? 3'd6 : 3'd4)) begin
          state_d = WAIT_RSP;
          cnt_d = '0;
          got_hi_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt + 1'b1;
        if (rx_cmd && we) begin
          state_d = DONE;
          err_d = i_rx_dat[6:0] != 7'h70;
          dat_d = 8'h00;
        end else if (rx_cmd && !got_hi && i_rx_dat[6:4] == 3'd4) begin
          hi_d = i_rx_dat[3:0];
          got_hi_d = 1'b1;
        end else if (rx_cmd) begin
          state_d = DONE;
          err_d = !rsp_ok;
          dat_d = rsp_ok ? {hi, i_rx_dat[3:0]} : 8'h00;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d = 1'b1;
          dat_d = 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
    if (((state == IDLE && !i_cs) || state == WAIT_RSP) && can_tx && i_stream_valid) begin
      tx_start_d = 1'b1;
      stream_ready_d = 1'b1;
      tx_dat_d = i_stream_dat & 8'h7F;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      we <= 1'b0;
      addr <= '0;
      wdat <= '0;
      idx <= '0;
      cnt <= '0;
      hi <= '0;
      got_hi <= 1'b0;
      o_dat <= '0;
      o_err <= 1'b0;
      o_tx_dat <= '0;
      o_tx_start <= 1'b0;
      o_stream_ready <= 1'b0;
      o_stream_dat <= '0;
      o_stream_valid <= 1'b0;
    end else begin
      state <= state_d;
      we <= we_d;
      addr <= addr_d;
      wdat <= wdat_d;
      idx <= idx_d;
      cnt <= cnt_d;
      hi <= hi_d;
      got_hi <= got_hi_d;
      o_dat <= dat_d;
      o_err <= err_d;
      o_tx_dat <= tx_dat_d;
      o_tx_start <= tx_start_d;
      o_stream_ready <= stream_ready_d;
      o_stream_valid <= rx_data;
      if (rx_data) o_stream_dat <= i_rx_dat & 8'h7F;
    end
endmodule

// File: tb/tb_uart_bus_host.sv
// tb_uart_bus_host: directed + randomized bus transactions checked against a protocol-level model.
module tb_uart_bus_host;
  localparam int TO = 50;
  typedef logic [7:0] bq_t[$];
  logic i_clk, i_reset_n, i_cs, i_we, i_tx_ready, i_rx_received_pulse, i_stream_valid;
  logic [15:0] i_addr;
  logic [7:0] i_dat, i_rx_dat, i_stream_dat;
  logic [7:0] o_dat, o_tx_dat, o_stream_dat;
  logic o_ack, o_err, o_busy, o_tx_start, o_stream_ready, o_stream_valid;
  int tests = 0, fails = 0, cyc = 0, last_start = 0, ack_cnt = 0, ack_cyc = 0, viol = 0, bl, acks;
  logic [7:0] ack_dat;
  logic ack_err, prev_start = 1'b0, rw;
  logic [7:0] rr0, rr1;
  bq_t txq, rsq;

  uart_bus_host #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr),
    .i_dat(i_dat), .o_dat(o_dat), .o_ack(o_ack), .o_err(o_err), .o_busy(o_busy),
    .o_tx_dat(o_tx_dat), .o_tx_start(o_tx_start), .i_tx_ready(i_tx_ready),
    .i_rx_dat(i_rx_dat), .i_rx_received_pulse(i_rx_received_pulse),
    .i_stream_dat(i_stream_dat), .i_stream_valid(i_stream_valid),
    .o_stream_ready(o_stream_ready), .o_stream_dat(o_stream_dat), .o_stream_valid(o_stream_valid)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // uart_tx stand-in: after each start, ready goes low for 0..3 cycles
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      if (o_tx_start === 1'b1) begin
        bl = $urandom_range(0, 3);
        if (bl > 0) begin
          i_tx_ready = 1'b0;
          repeat (bl) @(negedge i_clk);
          i_tx_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (o_tx_start === 1'b1) begin
        txq.push_back(o_tx_dat);
        last_start = cyc;
        if (prev_start) viol++;
      end
      prev_start = o_tx_start === 1'b1;
      if (o_ack === 1'b1) begin
        ack_cnt++;
        ack_dat = o_dat;
        ack_err = o_err;
        ack_cyc = cyc;
      end
      if (o_stream_valid === 1'b1) rsq.push_back(o_stream_dat);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
    if (i_stream_valid && o_stream_ready === 1'b1) i_stream_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_dat = b;
    i_rx_received_pulse = 1'b1;
    step();
    i_rx_received_pulse = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_dat, o_ack, o_err, o_busy, o_tx_dat, o_tx_start, o_stream_ready, o_stream_dat, o_stream_valid});
  endfunction

  function automatic bq_t model_cmd(input bit we, input logic [15:0] a, input logic [7:0] d);
    bq_t q;
    for (int i = 0; i < 4; i++) q.push_back(8'(128 + 16 * i + ((a >> (12 - 4 * i)) & 16'hF)));
    if (we) begin
      q.push_back(8'hC0 | (d >> 4));
      q.push_back(8'hD0 | (d & 8'h0F));
      q.push_back(8'hF0);
    end else q.push_back(8'hE0);
    return q;
  endfunction

  function automatic void model_rsp(input bit we, input int n, input logic [7:0] r0, input logic [7:0] r1,
                                    output bit to, output bit err, output logic [7:0] dat);
    to = 1'b0;
    err = 1'b0;
    dat = 8'h00;
    if (n == 0) begin to = 1'b1; err = 1'b1; end
    else if (we) err = r0 != 8'hF0;
    else if (r0[7:4] != 4'hC) err = 1'b1;
    else if (n == 1) begin to = 1'b1; err = 1'b1; end
    else if (r1[7:4] != 4'hD) err = 1'b1;
    else dat = {r0[3:0], r1[3:0]};
  endfunction

  task automatic run_txn(input string nm, input bit we, input logic [15:0] a, input logic [7:0] d,
                         input bit sv, input logic [7:0] sd, input bit xe, input logic [7:0] xb,
                         input int n, input logic [7:0] r0, input logic [7:0] r1);
    bq_t exp;
    int base;
    bit to, e;
    logic [7:0] ed;
    exp = model_cmd(we, a, d);
    if (sv) exp.push_back({1'b0, sd[6:0]});
    model_rsp(we, n, r0, r1, to, e, ed);
    txq.delete();
    base = ack_cnt;
    i_cs = 1'b1;
    i_we = we;
    i_addr = a;
    i_dat = d;
    if (sv) begin
      i_stream_valid = 1'b1;
      i_stream_dat = sd;
    end
    step();
    i_cs = 1'b0;
    i_we = !we;
    i_addr = 16'($urandom);
    i_dat = 8'($urandom);
    check({nm, ":busy"}, 32'(o_busy), 1);
    for (int i = 0; i < 200 && txq.size() < exp.size(); i++) step();
    check({nm, ":ntx"}, txq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < txq.size(); i++)
      check($sformatf("%s:tx%0d", nm, i), 32'(txq[i]), 32'(exp[i]));
    if (xe) begin
      rsq.delete();
      send_rx(xb);
      check({nm, ":srx_n"}, rsq.size(), 1);
      check({nm, ":srx_d"}, rsq.size() > 0 ? 32'(rsq[0]) : 32'hFFFF, 32'(xb & 8'h7F));
    end
    for (int k = 0; k < n && ack_cnt == base; k++) send_rx(k == 0 ? r0 : r1);
    for (int i = 0; i < TO + 20 && ack_cnt == base; i++) step();
    check({nm, ":ack"}, ack_cnt, base + 1);
    check({nm, ":err"}, 32'(ack_err), 32'(e));
    if (to || (!we && !e)) check({nm, ":dat"}, 32'(ack_dat), 32'(ed));
    if (to) check({nm, ":tmo"}, ack_cyc - last_start, TO);
    step();
    check({nm, ":idle"}, 32'({o_busy, o_ack}), 0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_cs = 1'b0;
    i_we = 1'b0;
    i_addr = '0;
    i_dat = '0;
    i_rx_dat = '0;
    i_rx_received_pulse = 1'b0;
    i_stream_dat = '0;
    i_stream_valid = 1'b0;
    step();
    step();
    check("reset", outs(), 0);
    i_reset_n = 1'b1;
    step();
    acks = ack_cnt;
    rsq.delete();
    send_rx(8'hF0);
    step();
    check("idle_drop:ack", ack_cnt, acks);
    check("idle_drop:srx", rsq.size(), 0);
    check("idle_drop:busy", 32'(o_busy), 0);
    run_txn("wr1234", 1'b1, 16'h1234, 8'hAB, 1'b0, 8'h00, 1'b0, 8'h00, 1, 8'hF0, 8'h00);
    run_txn("rd00FF", 1'b0, 16'h00FF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41, 2, 8'hC5, 8'hDA);
    run_txn("mismatch", 1'b0, 16'h4242, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 2, 8'hD3, 8'hC1);
    run_txn("timeout", 1'b0, 16'h0F0F, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'h00);
    run_txn("stream", 1'b0, 16'h3C5A, 8'h00, 1'b1, 8'hC7, 1'b0, 8'h00, 2, 8'hC1, 8'hD2);
    for (int t = 0; t < 8; t++) begin
      rw = 1'($urandom);
      if (rw) rr0 = ($urandom_range(0, 4) == 0) ? {4'hF, 4'($urandom_range(1, 15))} : 8'hF0;
      else rr0 = {($urandom_range(0, 4) == 0) ? 4'hD : 4'hC, 4'($urandom)};
      rr1 = {4'hD, 4'($urandom)};
      run_txn($sformatf("rnd%0d", t), rw, 16'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b0, 8'h00,
              rw ? 1 : 2, rr0, rr1);
    end
    txq.delete();
    acks = ack_cnt;
    i_cs = 1'b1;
    i_we = 1'b1;
    i_addr = 16'h7777;
    i_dat = 8'h11;
    step();
    i_cs = 1'b0;
    for (int i = 0; i < 100 && txq.size() < 3; i++) step();
    check("rst_mid:pre", txq.size(), 3);
    #2 i_reset_n = 1'b0;
    #1 check("rst_mid:outs", outs(), 0);
    step();
    step();
    i_reset_n = 1'b1;
    repeat (3) step();
    check("rst_mid:noack", ack_cnt, acks);
    check("rst_mid:busy", 32'(o_busy), 0);
    run_txn("wr_after", 1'b1, 16'hBEEF, 8'h5C, 1'b0, 8'h00, 1'b0, 8'h00, 1, 8'hF0, 8'h00);
    check("spacing", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_bus_host.md
Name: uart_bus_host

Overview:
- Host-side initiator for the UART command protocol.
- Converts local bus read/write requests into command bytes (bit7=1) and parses the remote response bytes.
- Passes data-channel bytes (bit7=0) through in both directions.
- Sits between a local bus master and a uart_tx/uart_rx pair, at the opposite end of the link from a remote UART bus bridge.

Parameters:
TIMEOUT, 100000, cycles allowed in WAIT_RSP before the transaction ends with error.

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_cs  in  1  bus request strobe
i_we  in  1  1=write, 0=read
i_addr  in  16  remote address
i_dat  in  8  write data
o_dat  out  8  read data, valid when o_ack=1
o_ack  out  1  one-cycle completion pulse
o_err  out  1  error flag, valid when o_ack=1
o_busy  out  1  transaction in progress
o_tx_dat  out  8  byte to uart_tx
o_tx_start  out  1  start pulse to uart_tx
i_tx_ready  in  1  uart_tx idle
i_rx_dat  in  8  byte from uart_rx
i_rx_received_pulse  in  1  uart_rx byte strobe
i_stream_dat  in  8  data-channel tx byte (bit7 forced 0)
i_stream_valid  in  1  tx stream byte offered
o_stream_ready  out  1  tx stream byte accepted this cycle
o_stream_dat  out  8  data-channel rx byte
o_stream_valid  out  1  one-cycle rx stream strobe

Behaviour:
- Clock and reset: one clock (i_clk); reset is asynchronous and active-low (i_reset_n).
- Reset values: all outputs 0; state IDLE; counters 0.
- Byte encoding: every protocol byte is {1, tag[2:0], nib[3:0]}.
  - Command tags: 0..3 = addr nibbles [15:12],[11:8],[7:4],[3:0]; 4/5 = write data hi/lo nibble; 6 = execute read (nib 0); 7 = execute write (nib 0).
  - Write sequence: tags 0,1,2,3,4,5,7 (7 bytes). Read sequence: tags 0,1,2,3,6 (5 bytes).
  - Response tags: read = tag4 (hi) then tag5 (lo); write = tag7 with nib 0. Any other bit7=1 byte in WAIT_RSP is an error.
- States:
  - IDLE: i_cs=1 captures i_we/i_addr/i_dat; o_busy=1 from the next cycle; go to SEND with byte index 0. i_cs is ignored outside IDLE.
  - SEND: if i_tx_ready=1 and no start was issued last cycle, drive o_tx_start=1 for exactly one cycle with the current byte and increment the index. After the last byte, go to WAIT_RSP and clear the timeout counter.
  - WAIT_RSP: bit7=1 rx bytes are matched against the expected tag sequence.
    - Read: the tag4 nibble is stored; on the tag5 byte, go to DONE with o_dat={hi,lo}.
    - Mismatch: go to DONE with err=1.
    - Timeout counter reaching TIMEOUT-1: go to DONE with err=1 and o_dat=0.
  - DONE: o_ack=1 for one cycle, o_err as set; o_busy=0 the next cycle; return to IDLE.
  - A same-cycle i_cs in DONE is ignored.
- o_tx_start rule: never high in two consecutive cycles (uart_tx drops o_ready one cycle after accepting start).
- Tx stream:
  - Serviced only in IDLE and WAIT_RSP, when i_tx_ready=1 and the start-spacing rule allows.
  - o_stream_ready=o_tx_start for that byte; o_tx_dat={0,i_stream_dat[6:0]}.
  - A command has priority: an i_cs capture in IDLE blocks stream service that cycle. Command bytes are never interleaved with stream bytes.
- Rx stream: a bit7=0 rx byte in any state produces o_stream_valid=1 for one cycle, o_stream_dat={0,i_rx_dat[6:0]}. Such bytes never affect the protocol state or the timeout.
- A bit7=1 rx byte outside WAIT_RSP is dropped.
- Reset mid-transaction: immediate return to IDLE; no ack is generated.

Test Plan:
- Write 0x1234 data 0xAB: tx = 0x81,0x92,0xA3,0xB4,0xCA,0xDB,0xF0, starts ≥2 cycles apart; rx 0xF0 -> o_ack pulse, o_err=0, o_busy falls the next cycle.
- Read 0x00FF: tx = 0x80,0x90,0xAF,0xBF,0xE0; rx 0xC5,0xDA -> o_ack, o_dat=0x5A, o_err=0.
- Read with rx 0xD3 first (tag5 before tag4) -> o_ack with o_err=1; TIMEOUT=50 with no response -> o_ack, o_err=1, o_dat=0, exactly 50 cycles after the last start.
- Stream: rx 0x41 during WAIT_RSP -> o_stream_valid with 0x41, read still completes. i_stream_valid with 0xC7 in IDLE and i_cs in the same cycle -> command bytes first; 0x47 sent during WAIT_RSP.
- i_reset_n low after the third command byte -> all outputs 0 asynchronously; a new write afterwards produces the full 7-byte sequence.
